// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte request channel from the display logic into the HD44780 controller.
// The master offers a command/data byte; the slave (controller) accepts it
// on a clock edge where in_valid and in_ready are both high.
interface lcd_hd44780_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-compatible character LCD controller: self-initialising, write-only,
// fixed busy waits (the busy flag is never read), 4- or 8-bit bus.
// The LCD pins are registered from the FSM state, so they trail it by one
// cycle: data/rs appear one cycle after SETUP is entered and lcd_en is high
// for the EN_HIGH_CYC cycles following EN_HI entry + 1.
module lcd_hd44780_ctrl #(
  parameter int BUS_WIDTH      = 8,
  parameter int EN_HIGH_CYC    = 12,
  parameter int EN_LOW_CYC     = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000,
  parameter int WAKE_WAIT_CYC  = 205000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_hd44780_ctrl_if.slave     in_if,
  output logic                  init_done,
  output logic [BUS_WIDTH-1:0]  lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en
);

  localparam int MAX_A    = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
  localparam int MAX_B    = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_C    = (WAKE_WAIT_CYC > PWRUP_WAIT_CYC) ? WAKE_WAIT_CYC : PWRUP_WAIT_CYC;
  localparam int MAX_AB   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_WAIT = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  localparam logic [CW-1:0] PWRUP_LAST  = CW'(PWRUP_WAIT_CYC - 1);
  localparam logic [CW-1:0] EN_HI_LOAD  = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] EN_LO_LOAD  = CW'(EN_LOW_CYC - 1);
  localparam logic [CW-1:0] CMD_LOAD    = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] WAKE_LOAD   = CW'(WAKE_WAIT_CYC - 1);
  // 8-bit init has 8 ROM entries, 4-bit has 9 (extra single 0x2 nibble)
  localparam logic [3:0]    LAST_IDX    = (BUS_WIDTH == 8) ? 4'd7 : 4'd8;

  typedef enum logic [2:0] {
    PWRUP, INIT_LOAD, SETUP, EN_HI, EN_LO, NIB2, WAIT, IDLE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           rs_q, rs_d;
  logic           single_q, single_d;   // strobe only the high nibble (4-bit wake-up writes)
  logic           wake_q, wake_d;       // this write is an init wake-up: use the long wait
  logic           nib_q, nib_d;         // 0: high nibble on the bus, 1: low nibble
  logic [3:0]     idx_q, idx_d;
  logic           init_done_q, init_done_d;
  logic           lcd_en_q, lcd_rs_q;
  logic [BUS_WIDTH-1:0] lcd_data_q;
  logic [BUS_WIDTH-1:0] bus_val;
  logic [CW-1:0]  wait_load;

  // Init ROM; single-nibble 4-bit entries keep the nibble in bits 7:4
  function automatic logic [7:0] rom_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h0C;
    if (BUS_WIDTH == 8) begin
      case (idx)
        4'd0, 4'd1, 4'd2: b = 8'h30;
        4'd3:             b = 8'h38;
        4'd4:             b = 8'h08;
        4'd5:             b = 8'h01;
        4'd6:             b = 8'h06;
        default:          b = 8'h0C;
      endcase
    end else begin
      case (idx)
        4'd0, 4'd1, 4'd2: b = 8'h30;
        4'd3:             b = 8'h20;
        4'd4:             b = 8'h28;
        4'd5:             b = 8'h08;
        4'd6:             b = 8'h01;
        4'd7:             b = 8'h06;
        default:          b = 8'h0C;
      endcase
    end
    return b;
  endfunction

  generate
    if (BUS_WIDTH == 8) begin : g_bus8
      assign bus_val = byte_q;
    end else if (BUS_WIDTH == 4) begin : g_bus4
      assign bus_val = nib_q ? byte_q[3:0] : byte_q[7:4];
    end else begin : g_bad_width
      $error("lcd_hd44780_ctrl: BUS_WIDTH must be 4 or 8");
    end
  endgenerate

  // Select the post-write wait: wake-up, Clear/Return Home, or normal
  always_comb begin
    wait_load = CMD_LOAD;
    if (wake_q)
      wait_load = WAKE_LOAD;
    else if (!rs_q && (byte_q[7:2] == 6'd0) && (byte_q != 8'd0))
      wait_load = CLR_LOAD;
  end

  // Next-state logic: power-up wait, init ROM walk, strobe sequencing, waits
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    single_d    = single_q;
    wake_d      = wake_q;
    nib_d       = nib_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      PWRUP: begin
        // counter starts cleared by reset, so this one counts up
        if (cnt_q == PWRUP_LAST) begin
          state_d = INIT_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_LOAD: begin
        byte_d   = rom_byte(idx_q);
        rs_d     = 1'b0;
        single_d = (BUS_WIDTH == 4) && (idx_q < 4'd4);
        wake_d   = (idx_q < 4'd3);
        nib_d    = 1'b0;
        state_d  = SETUP;
        cnt_d    = CW'(1);
      end
      IDLE: begin
        if (in_if.in_valid) begin
          byte_d   = in_if.in_data;
          rs_d     = in_if.in_rs;
          single_d = 1'b0;
          wake_d   = 1'b0;
          nib_d    = 1'b0;
          state_d  = SETUP;
          cnt_d    = CW'(1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EN_HI;
          cnt_d   = EN_HI_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EN_HI: begin
        if (cnt_q == '0) begin
          state_d = EN_LO;
          cnt_d   = EN_LO_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EN_LO: begin
        if (cnt_q == '0) begin
          if ((BUS_WIDTH == 4) && !single_q && !nib_q) begin
            state_d = NIB2;
            nib_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_load;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      NIB2: begin
        // NIB2 is the first of the two setup cycles for the low nibble
        state_d = SETUP;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!init_done_q) begin
            if (idx_q == LAST_IDX) begin
              state_d     = IDLE;
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = INIT_LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      single_q    <= 1'b0;
      wake_q      <= 1'b0;
      nib_q       <= 1'b0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      single_q    <= single_d;
      wake_q      <= wake_d;
      nib_q       <= nib_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // LCD pin registers; rs/data only move during setup so they stay put around en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= '0;
    end else begin
      lcd_en_q <= (state_q == EN_HI);
      if ((state_q == SETUP) || (state_q == NIB2)) begin
        lcd_rs_q   <= rs_q;
        lcd_data_q <= bus_val;
      end
    end
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign init_done      = init_done_q;
  assign lcd_en         = lcd_en_q;
  assign lcd_rs         = lcd_rs_q;
  assign lcd_data       = lcd_data_q;
  assign lcd_rw         = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: one 8-bit and one 4-bit instance
// sharing clock and reset, with short sim waits.
module tb_lcd_hd44780_ctrl;

  localparam int PW = 20, WK = 10, CM = 4, CL = 8, EH = 2, EL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_hd44780_ctrl_if if8 ();
  lcd_hd44780_ctrl_if if4 ();

  logic       init_done8, lcd_rs8, lcd_rw8, lcd_en8;
  logic [7:0] lcd_data8;
  logic       init_done4, lcd_rs4, lcd_rw4, lcd_en4;
  logic [3:0] lcd_data4;

  lcd_hd44780_ctrl #(
    .BUS_WIDTH(8), .EN_HIGH_CYC(EH), .EN_LOW_CYC(EL), .CMD_WAIT_CYC(CM),
    .CLR_WAIT_CYC(CL), .WAKE_WAIT_CYC(WK), .PWRUP_WAIT_CYC(PW)
  ) u8 (
    .clk(clk), .rst(rst), .in_if(if8.slave), .init_done(init_done8),
    .lcd_data(lcd_data8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_en(lcd_en8)
  );

  lcd_hd44780_ctrl #(
    .BUS_WIDTH(4), .EN_HIGH_CYC(EH), .EN_LOW_CYC(EL), .CMD_WAIT_CYC(CM),
    .CLR_WAIT_CYC(CL), .WAKE_WAIT_CYC(WK), .PWRUP_WAIT_CYC(PW)
  ) u4 (
    .clk(clk), .rst(rst), .in_if(if4.slave), .init_done(init_done4),
    .lcd_data(lcd_data4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_en(lcd_en4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe capture: {rs,data} at each rising lcd_en, plus bus stability while en is high
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic       en8_prev = 1'b0, en4_prev = 1'b0;
  logic [8:0] bus8_prev = '0;
  logic [4:0] bus4_prev = '0;
  int         stab_err = 0;

  always @(negedge clk) begin
    if (lcd_en8 && !en8_prev) q8.push_back({lcd_rs8, lcd_data8});
    if (lcd_en4 && !en4_prev) q4.push_back({lcd_rs4, lcd_data4});
    if (lcd_en8 && en8_prev && ({lcd_rs8, lcd_data8} != bus8_prev)) stab_err++;
    if (lcd_en4 && en4_prev && ({lcd_rs4, lcd_data4} != bus4_prev)) stab_err++;
    en8_prev  <= lcd_en8;
    en4_prev  <= lcd_en4;
    bus8_prev <= {lcd_rs8, lcd_data8};
    bus4_prev <= {lcd_rs4, lcd_data4};
  end

  logic [8:0] exp8 [8]  = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
  logic [4:0] exp4 [14] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00,
                            5'h08, 5'h00, 5'h01, 5'h00, 5'h06, 5'h00, 5'h0C};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until both instances finish init; the 8-bit side may be holding
  // in_valid with changing junk, dropped the moment in_ready is seen.
  task automatic wait_init();
    for (int i = 0; i < 3000; i++) begin
      if (init_done8 && init_done4) break;
      tick();
      if (if8.in_ready) if8.in_valid = 1'b0;
      else if8.in_data = if8.in_data + 8'h13;
    end
    check("init_done8", init_done8, 1);
    check("init_done4", init_done4, 1);
    check("init_ready8", if8.in_ready, 1);
    check("init_ready4", if4.in_ready, 1);
    check("init8_count", q8.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q8.size()) check($sformatf("init8_byte%0d", i), q8[i], exp8[i]);
    check("init4_count", q4.size(), 14);
    for (int i = 0; i < 14; i++)
      if (i < q4.size()) check($sformatf("init4_nib%0d", i), q4[i], exp4[i]);
    $display("init: 8-bit strobes=%0d 4-bit strobes=%0d", q8.size(), q4.size());
    q8.delete();
    q4.delete();
  endtask

  task automatic write8(input logic rs, input logic [7:0] d, input int exp_ready);
    check("w8_ready_pre", if8.in_ready, 1);
    if8.in_valid = 1'b1;
    if8.in_rs    = rs;
    if8.in_data  = d;
    tick();                                // accept edge, cycle 0
    if8.in_rs   = ~rs;
    if8.in_data = ~d;
    for (int k = 1; k <= exp_ready; k++) begin
      tick();
      if8.in_data = if8.in_data + 8'h11;
      check($sformatf("w8_ready_c%0d", k), if8.in_ready, (k == exp_ready) ? 1 : 0);
      if (k <= 7) check($sformatf("w8_en_c%0d", k), lcd_en8, (k >= 3 && k <= 4) ? 1 : 0);
      check($sformatf("w8_bus_c%0d", k), {lcd_rs8, lcd_data8}, {rs, d});
      if (k == exp_ready) if8.in_valid = 1'b0;
    end
    check("w8_pulses", q8.size(), 1);
    if (q8.size() > 0) check("w8_pulse_val", q8[0], {rs, d});
    $display("write8 rs=%0d data=0x%02h ready_at=%0d", rs, d, exp_ready);
    q8.delete();
  endtask

  task automatic write4(input logic rs, input logic [7:0] d, input int exp_ready);
    check("w4_ready_pre", if4.in_ready, 1);
    if4.in_valid = 1'b1;
    if4.in_rs    = rs;
    if4.in_data  = d;
    tick();
    if4.in_rs   = ~rs;
    if4.in_data = ~d;
    for (int k = 1; k <= exp_ready; k++) begin
      tick();
      if4.in_data = if4.in_data + 8'h11;
      check($sformatf("w4_ready_c%0d", k), if4.in_ready, (k == exp_ready) ? 1 : 0);
      if (k <= 14)
        check($sformatf("w4_en_c%0d", k), lcd_en4,
              (k == 3 || k == 4 || k == 10 || k == 11) ? 1 : 0);
      if (k <= 7) check($sformatf("w4_hi_c%0d", k), {lcd_rs4, lcd_data4}, {rs, d[7:4]});
      else        check($sformatf("w4_lo_c%0d", k), {lcd_rs4, lcd_data4}, {rs, d[3:0]});
      if (k == exp_ready) if4.in_valid = 1'b0;
    end
    check("w4_pulses", q4.size(), 2);
    if (q4.size() > 1) begin
      check("w4_pulse_hi", q4[0], {rs, d[7:4]});
      check("w4_pulse_lo", q4[1], {rs, d[3:0]});
    end
    $display("write4 rs=%0d data=0x%02h ready_at=%0d", rs, d, exp_ready);
    q4.delete();
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.in_rs = 1'b0; if8.in_data = 8'h00;
    if4.in_valid = 1'b0; if4.in_rs = 1'b0; if4.in_data = 8'h00;
    rst = 1'b0;
    tick();
    tick();
    check("rst_en8", lcd_en8, 0);
    check("rst_rs8", lcd_rs8, 0);
    check("rst_rw8", lcd_rw8, 0);
    check("rst_data8", lcd_data8, 0);
    check("rst_ready8", if8.in_ready, 0);
    check("rst_done8", init_done8, 0);
    check("rst_data4", lcd_data4, 0);
    check("rst_ready4", if4.in_ready, 0);

    // Release with in_valid held high and changing data during init
    if8.in_valid = 1'b1; if8.in_rs = 1'b1; if8.in_data = 8'h55;
    rst = 1'b1;
    tick();
    check("pwrup_ready8", if8.in_ready, 0);
    check("pwrup_en8", lcd_en8, 0);
    wait_init();

    // 8-bit writes: data, clear/home boundaries, back-to-back
    write8(1'b1, 8'h41, 2 + EH + EL + CM);
    write8(1'b0, 8'h01, 2 + EH + EL + CL);
    write8(1'b1, 8'h01, 2 + EH + EL + CM);
    write8(1'b0, 8'h02, 2 + EH + EL + CL);
    write8(1'b0, 8'h03, 2 + EH + EL + CL);
    write8(1'b0, 8'h04, 2 + EH + EL + CM);
    write8(1'b0, 8'h00, 2 + EH + EL + CM);

    // 4-bit writes
    write4(1'b1, 8'hA5, 2 * (2 + EH + EL) + CM);
    write4(1'b0, 8'h01, 2 * (2 + EH + EL) + CL);
    write4(1'b1, 8'h3C, 2 * (2 + EH + EL) + CM);

    // Reset in the middle of an enable strobe
    if8.in_valid = 1'b1; if8.in_rs = 1'b1; if8.in_data = 8'h42;
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_en_before", lcd_en8, 1);
    rst = 1'b0;
    #1;
    check("mid_en8", lcd_en8, 0);
    check("mid_rs8", lcd_rs8, 0);
    check("mid_data8", lcd_data8, 0);
    check("mid_ready8", if8.in_ready, 0);
    check("mid_done8", init_done8, 0);
    check("mid_done4", init_done4, 0);
    check("mid_en4", lcd_en4, 0);
    check("mid_data4", lcd_data4, 0);
    $display("reset asserted mid-strobe at %0t", $time);
    tick();
    tick();
    rst = 1'b1;
    q8.delete();
    q4.delete();
    wait_init();

    check("bus_stable_during_en", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

Parametrised HD44780-compatible character-LCD controller: the next generation of the LCD_Driver block. It powers up and initialises the panel on its own, then accepts command/data bytes through a valid/ready handshake. It generates the LCD bus strobes, selectable 4- or 8-bit bus and per-command busy waits, with no polling of the busy flag. It sits between the system-side display logic and the LCD pins.

## Interface
Parameters:
- BUS_WIDTH, 8: LCD data bus width; 4 or 8 only, any other value is an elaboration error.
- EN_HIGH_CYC, 12: clk cycles lcd_en is held high per strobe (≥1).
- EN_LOW_CYC, 25: clk cycles lcd_en is held low after a strobe, with data held (≥1).
- CMD_WAIT_CYC, 2000: wait after a normal command/data write (40 µs at 50 MHz).
- CLR_WAIT_CYC, 82000: wait after Clear Display (0x01) or Return Home (0x02/0x03) with rs=0.
- WAKE_WAIT_CYC, 205000: wait after each init wake-up write.
- PWRUP_WAIT_CYC, 750000: wait after reset release before the first init write.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a byte.
- in_ready  out  1  controller can accept; transfer on a clk edge with in_valid && in_ready.
- in_rs  in  1  0 = command, 1 = data (character).
- in_data  in  8  byte to write.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- lcd_data  out  BUS_WIDTH  LCD DB bus; in 4-bit mode drives DB7..DB4.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  constant 0 (write only).
- lcd_en  out  1  LCD enable strobe.

## Operation
- States: PWRUP, INIT_LOAD, SETUP, EN_HI, EN_LO, NIB2 (4-bit only), WAIT, IDLE.
- PWRUP: count PWRUP_WAIT_CYC, then INIT_LOAD.
- Init ROM, 8-bit mode: 0x30, 0x30, 0x30 (each followed by WAKE_WAIT_CYC), then 0x38, 0x08, 0x01, 0x06, 0x0C with standard waits (0x01 uses CLR_WAIT_CYC).
- Init ROM, 4-bit mode:
  - Single-nibble wake writes 0x3, 0x3, 0x3, each followed by WAKE_WAIT_CYC.
  - Then single nibble 0x2, followed by CMD_WAIT_CYC.
  - Then full two-nibble 0x28, 0x08, 0x01, 0x06, 0x0C.
- All init writes use lcd_rs=0. After the last init wait, init_done=1 and the state is IDLE.
- IDLE: in_ready=1. On accept, latch in_rs and in_data, drop in_ready, then go to SETUP.
- Write strobe: SETUP (2 cycles, rs/data valid, en=0) → EN_HI (EN_HIGH_CYC, en=1) → EN_LO (EN_LOW_CYC, en=0, data held).
- 4-bit mode: the high nibble is strobed first. NIB2 then loads the low nibble and repeats SETUP/EN_HI/EN_LO.
- WAIT: counts CLR_WAIT_CYC if rs=0 and data[7:2]==0 and data!=0, otherwise CMD_WAIT_CYC. Then the state returns to IDLE.
- Wait counter width is $clog2 of the largest wait parameter plus 1. The counter is loaded on state entry and ends at zero, with no wrap.
- in_valid/in_data while in_ready=0 are ignored. Latched values are unaffected by input changes after accept.

## Timing
- Reset asserted (async): lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0, in_ready=0, init_done=0, state=PWRUP, counters cleared.
- lcd_en drops in the same instant as reset, including mid-strobe. On release, init restarts from PWRUP.
- Accept edge = cycle 0. lcd_rs/lcd_data are valid from cycle 1, and lcd_en=1 for cycles 3..2+EN_HIGH_CYC.
- 8-bit: in_ready returns high exactly 2+EN_HIGH_CYC+EN_LOW_CYC+W cycles after the accept edge, where W is the selected wait.
- 4-bit: in_ready returns high exactly 2·(2+EN_HIGH_CYC+EN_LOW_CYC)+W cycles after the accept edge.
- lcd_rs/lcd_data never change while lcd_en=1, nor during the following EN_LOW_CYC.
- At most one transfer is accepted per transaction. Back-to-back in_valid is accepted in the first IDLE cycle.

## Test plan
Sim parameters: PWRUP=20, WAKE=10, CMD=4, CLR=8, EN_HIGH=2, EN_LOW=3.
- Reset/init, BUS_WIDTH=8: release rst → 8 en pulses carrying 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C, all rs=0. init_done rises after the 0x0C wait, and in_ready=1.
- Data write, 8-bit: accept rs=1, data=0x41 → lcd_data=0x41 and rs=1 from cycle 1; en high cycles 3–4; in_ready back at cycle 2+2+3+4=11.
- Clear wait: accept rs=0, 0x01 → in_ready back at cycle 15. Accept rs=1, 0x01 → cycle 11 (CMD wait).
- 4-bit mode: accept rs=1, 0xA5 → first strobe lcd_data=0xA, second 0x5; in_ready back at cycle 2·7+4=18. Init shows 4 single nibbles 3,3,3,2 before the 0x28 nibble pair.
- Handshake: hold in_valid high with changing data during init and during a write → nothing is accepted while in_ready=0, and the latched byte is unchanged.
- Reset mid-strobe: assert rst while lcd_en=1 → lcd_en=0 immediately, all outputs at reset values; after release, the full init sequence repeats.
